mc_ctrl: RTL

Multi-cycle MIPS main controller FSM. It is the issuing end of the ALU operation interface: it decodes the instruction register, drives the 4-bit ALU op code into the datapath ALU, and consumes the ALU's Zero flag for beq. It also sequences the IR/PC/register-file/data-memory write enables so that each instruction runs over 2–5 cycles.

---
 rtl/mc_ctrl_if.sv | 32 +++
 rtl/mc_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// ALU-operation / control bundle between the main controller and the datapath.
// master: controller (consumes Instr/Zero, drives enables, selects and ALUOp).
// slave : datapath   (drives Instr/Zero, consumes the control outputs).
interface mc_ctrl_if #(
  parameter int unsigned W_OP = 4
);
  logic [31:0]     Instr;
  logic            Zero;
  logic            IRWr;
  logic            PCWr;
  logic [1:0]      NPCSel;
  logic            RegWr;
  logic [1:0]      RegDst;
  logic [1:0]      WDSel;
  logic            MemWr;
  logic [W_OP-1:0] ALUOp;
  logic            ALUSrc;
  logic            ExtOp;
  logic [2:0]      State;

  modport master (
    input  Instr, Zero,
    output IRWr, PCWr, NPCSel, RegWr, RegDst, WDSel, MemWr,
           ALUOp, ALUSrc, ExtOp, State
  );

  modport slave (
    output Instr, Zero,
    input  IRWr, PCWr, NPCSel, RegWr, RegDst, WDSel, MemWr,
           ALUOp, ALUSrc, ExtOp, State
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller.
// Ports: clk, reset (sync, active-high), bus (mc_ctrl_if.master):
//   Instr/Zero in; IRWr, PCWr, NPCSel, RegWr, RegDst, WDSel, MemWr,
//   ALUOp, ALUSrc, ExtOp, State out.
// Write enables are Moore outputs of the state and are forced low while
// reset is high; decode outputs are combinational from Instr (and Zero for
// beq's NPCSel).
module mc_ctrl #(
  parameter int unsigned W_OP = 4
) (
  input  logic       clk,
  input  logic       reset,
  mc_ctrl_if.master  bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [W_OP-1:0] ALU_AND = W_OP'(0);
  localparam logic [W_OP-1:0] ALU_OR  = W_OP'(1);
  localparam logic [W_OP-1:0] ALU_ADD = W_OP'(2);
  localparam logic [W_OP-1:0] ALU_SUB = W_OP'(3);
  localparam logic [W_OP-1:0] ALU_LUI = W_OP'(4);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    ALUWB  = 3'd3,
    MEM    = 3'd4,
    MEMWB  = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_UNK
  } kind_t;

  state_t          state_q, state_d;
  kind_t           kind;
  logic [5:0]      op, funct;
  logic            irwr, pcwr, regwr, memwr;
  logic [1:0]      npcsel, regdst, wdsel;
  logic [W_OP-1:0] aluop;
  logic            alusrc, extop;
  logic            unused_instr_bits;

  assign op    = bus.Instr[31:26];
  assign funct = bus.Instr[5:0];
  assign unused_instr_bits = ^bus.Instr[25:6];

  // Instruction classification
  always_comb begin
    kind = K_UNK;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: kind = K_ADDU;
          FN_SUBU: kind = K_SUBU;
          FN_JR:   kind = K_JR;
          default: kind = K_UNK;
        endcase
      end
      OP_ORI:  kind = K_ORI;
      OP_LUI:  kind = K_LUI;
      OP_LW:   kind = K_LW;
      OP_SW:   kind = K_SW;
      OP_BEQ:  kind = K_BEQ;
      OP_J:    kind = K_J;
      OP_JAL:  kind = K_JAL;
      default: kind = K_UNK;
    endcase
  end

  // Datapath selects, independent of state
  always_comb begin
    aluop  = ALU_AND;
    alusrc = 1'b0;
    extop  = 1'b0;
    regdst = 2'd0;
    wdsel  = 2'd0;
    npcsel = 2'd0;
    case (kind)
      K_ADDU: begin aluop = ALU_ADD; regdst = 2'd1; end
      K_SUBU: begin aluop = ALU_SUB; regdst = 2'd1; end
      K_ORI:  begin aluop = ALU_OR;  alusrc = 1'b1; end
      K_LUI:  begin aluop = ALU_LUI; alusrc = 1'b1; end
      K_LW:   begin aluop = ALU_ADD; alusrc = 1'b1; extop = 1'b1; wdsel = 2'd1; end
      K_SW:   begin aluop = ALU_ADD; alusrc = 1'b1; extop = 1'b1; end
      K_BEQ:  begin aluop = ALU_SUB; extop = 1'b1; npcsel = {1'b0, bus.Zero}; end
      K_J:    npcsel = 2'd2;
      K_JAL:  begin npcsel = 2'd2; regdst = 2'd2; wdsel = 2'd2; end
      K_JR:   npcsel = 2'd3;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next state and per-state write enables
  always_comb begin
    state_d = FETCH;
    irwr    = 1'b0;
    pcwr    = 1'b0;
    regwr   = 1'b0;
    memwr   = 1'b0;
    case (state_q)
      FETCH: begin
        irwr    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        case (kind)
          K_J, K_JR, K_UNK: pcwr = 1'b1;
          K_JAL: begin pcwr = 1'b1; regwr = 1'b1; end
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        case (kind)
          K_ADDU, K_SUBU, K_ORI, K_LUI: state_d = ALUWB;
          K_LW, K_SW:                   state_d = MEM;
          K_BEQ:                        pcwr = 1'b1;
          default: ;
        endcase
      end
      ALUWB: begin
        regwr = 1'b1;
        pcwr  = 1'b1;
      end
      MEM: begin
        if (kind == K_SW) begin
          memwr = 1'b1;
          pcwr  = 1'b1;
        end else if (kind == K_LW) begin
          state_d = MEMWB;
        end
      end
      MEMWB: begin
        regwr = 1'b1;
        pcwr  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset suppresses every write so an abandoned instruction leaves no trace
  assign bus.IRWr   = irwr  & ~reset;
  assign bus.PCWr   = pcwr  & ~reset;
  assign bus.RegWr  = regwr & ~reset;
  assign bus.MemWr  = memwr & ~reset;
  assign bus.NPCSel = npcsel;
  assign bus.RegDst = regdst;
  assign bus.WDSel  = wdsel;
  assign bus.ALUOp  = aluop;
  assign bus.ALUSrc = alusrc;
  assign bus.ExtOp  = extop;
  assign bus.State  = state_q;

endmodule
